// File: rtl/sng_stream_array.sv
// Stochastic number generator array: latches one operand per lane, then compares it
// against the lane's shared Sobol word every cycle to emit a 2^LWID-bit unipolar stream.
module sng_stream_array #(
  parameter int RWID  = 8,
  parameter int LANES = 32,
  parameter int LWID  = 8,
  parameter int RLAT  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RWID-1:0]  in_data [LANES],
  input  logic             abort,
  output logic             rng_enable,
  input  logic [RWID-1:0]  rng_seq [LANES],
  output logic [LANES-1:0] bit_out,
  output logic             bit_valid,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  localparam logic [2:0] PRIME_LAST = 3'((RLAT > 0) ? RLAT - 1 : 0);

  state_t           state_reg;
  logic [2:0]       prime_cnt_reg;
  logic [LWID-1:0]  run_cnt_reg;
  logic             in_ready_reg;
  logic             rng_enable_reg;
  logic             bit_valid_reg;
  logic             done_reg;
  logic [LANES-1:0] bit_out_reg;
  logic [LANES-1:0] cmp_next;
  logic             accept;

  assign accept = (state_reg == IDLE) && in_ready_reg && in_valid && !abort;

  // Per-lane operand hold and unsigned strict comparator against the shared word.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [RWID-1:0] op_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_reg <= '0;
        end else if (accept) begin
          op_reg <= in_data[gi];
        end
      end

      assign cmp_next[gi] = (op_reg > rng_seq[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      prime_cnt_reg  <= '0;
      run_cnt_reg    <= '0;
      in_ready_reg   <= 1'b0;
      rng_enable_reg <= 1'b0;
      bit_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      bit_out_reg    <= '0;
    end else if (abort) begin
      // Cancel wins in every state; an aborted stream never produces done.
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b1;
      rng_enable_reg <= 1'b0;
      bit_valid_reg  <= 1'b0;
      done_reg       <= 1'b0;
      bit_out_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            in_ready_reg   <= 1'b0;
            rng_enable_reg <= 1'b1;
            prime_cnt_reg  <= '0;
            run_cnt_reg    <= '0;
            state_reg      <= (RLAT > 0) ? PRIME : RUN;
          end
        end
        PRIME: begin
          prime_cnt_reg <= prime_cnt_reg + 3'd1;
          if (prime_cnt_reg == PRIME_LAST) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          bit_out_reg   <= cmp_next;
          bit_valid_reg <= 1'b1;
          run_cnt_reg   <= run_cnt_reg + LWID'(1);
          // Enable drops together with the last compare so exactly 2^LWID words are consumed.
          if (&run_cnt_reg) begin
            state_reg      <= FLUSH;
            rng_enable_reg <= 1'b0;
            done_reg       <= 1'b1;
          end
        end
        FLUSH: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          bit_valid_reg <= 1'b0;
          done_reg      <= 1'b0;
          bit_out_reg   <= '0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign rng_enable = rng_enable_reg;
  assign bit_out    = bit_out_reg;
  assign bit_valid  = bit_valid_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_sng_stream_array.sv
// Bench for sng_stream_array: two instances (full-period 8-bit and short 16-bit streams)
// fed by a bench-side permutation RNG; every stream bit is predicted from the operand and word index.
module tb_sng_stream_array;
  localparam int RW  = 8;
  localparam int LA  = 32;
  localparam int RLA = 2;
  localparam int NA  = 256;
  localparam int LB  = 4;
  localparam int RLB = 0;
  localparam int NB  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_abort, a_rng_enable, a_bit_valid, a_done;
  logic [RW-1:0] a_in_data [LA];
  logic [RW-1:0] a_rng_seq [LA];
  logic [LA-1:0] a_bit_out;
  logic          b_in_valid, b_in_ready, b_abort, b_rng_enable, b_bit_valid, b_done;
  logic [RW-1:0] b_in_data [LB];
  logic [RW-1:0] b_rng_seq [LB];
  logic [LB-1:0] b_bit_out;

  sng_stream_array #(.RWID(RW), .LANES(LA), .LWID(8), .RLAT(RLA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .abort(a_abort), .rng_enable(a_rng_enable), .rng_seq(a_rng_seq),
    .bit_out(a_bit_out), .bit_valid(a_bit_valid), .done(a_done)
  );

  sng_stream_array #(.RWID(RW), .LANES(LB), .LWID(4), .RLAT(RLB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .abort(b_abort), .rng_enable(b_rng_enable), .rng_seq(b_rng_seq),
    .bit_out(b_bit_out), .bit_valid(b_bit_valid), .done(b_done)
  );

  // Word k of a lane is a permutation of k mod 256, so any 256 consecutive words cover every value.
  function automatic logic [7:0] rng_word(input int lane, input int unsigned c);
    logic [7:0] v, r;
    v = c[7:0];
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r ^ 8'(lane * 37);
  endfunction

  int unsigned   a_cnt, b_cnt;
  logic [RW-1:0] a_p1 [LA];
  logic [RW-1:0] a_p2 [LA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= 0;
      b_cnt <= 0;
      for (int i = 0; i < LA; i++) begin
        a_p1[i] <= '0;
        a_p2[i] <= '0;
      end
    end else begin
      if (a_rng_enable) a_cnt <= a_cnt + 1;
      if (b_rng_enable) b_cnt <= b_cnt + 1;
      for (int i = 0; i < LA; i++) begin
        a_p1[i] <= rng_word(i, a_cnt);
        a_p2[i] <= a_p1[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LA; i++) a_rng_seq[i] = a_p2[i];
    for (int i = 0; i < LB; i++) b_rng_seq[i] = rng_word(i, b_cnt);
  end

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] cur_ops [LA];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic sample(input bit use_b, output logic v, output logic d, output logic r,
                        output logic e, output logic [LA-1:0] bits);
    if (use_b) begin
      v = b_bit_valid; d = b_done; r = b_in_ready; e = b_rng_enable; bits = LA'(b_bit_out);
    end else begin
      v = a_bit_valid; d = a_done; r = a_in_ready; e = a_rng_enable; bits = a_bit_out;
    end
  endtask

  task automatic drive(input bit use_b, input logic valid, input bit rnd, input logic [7:0] val);
    if (use_b) begin
      b_in_valid = valid;
      for (int i = 0; i < LB; i++) b_in_data[i] = rnd ? 8'($urandom_range(0, 255)) : val;
    end else begin
      a_in_valid = valid;
      for (int i = 0; i < LA; i++) a_in_data[i] = rnd ? 8'($urandom_range(0, 255)) : val;
    end
  endtask

  // One stream: accept cur_ops, then check every observed cycle against the stream rules.
  task automatic run_stream(input bit use_b, input int abort_at, input int reset_at,
                            input bit hold_next, input logic [7:0] next_op);
    int rl, n, lanes, wait_cyc, en_cyc, rdy_low;
    int ones [LA];
    int exp_ones [LA];
    int unsigned c0;
    logic [7:0] ops [LA];
    logic [LA-1:0] exp_bits, got_bits;
    logic gv, gd, gr, ge;
    bit in_run;
    rl = use_b ? RLB : RLA;
    n = use_b ? NB : NA;
    lanes = use_b ? LB : LA;
    en_cyc = 0;
    rdy_low = 0;
    for (int i = 0; i < LA; i++) begin
      ops[i] = cur_ops[i]; ones[i] = 0; exp_ones[i] = 0;
    end
    if (use_b) begin
      b_in_valid = 1'b1;
      for (int i = 0; i < LB; i++) b_in_data[i] = ops[i];
    end else begin
      a_in_valid = 1'b1;
      for (int i = 0; i < LA; i++) a_in_data[i] = ops[i];
    end
    wait_cyc = 0;
    while (!(use_b ? b_in_ready : a_in_ready) && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check_eq("accept_timeout", 64'(wait_cyc >= 50), 64'(0));
    if (wait_cyc >= 50) return;
    @(posedge clk); #1;
    c0 = use_b ? b_cnt : a_cnt;
    if (hold_next) drive(use_b, 1'b1, 1'b0, next_op);
    else drive(use_b, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k <= rl + n + 1; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      sample(use_b, gv, gd, gr, ge, got_bits);
      if (ge) en_cyc++;
      if (!gr) rdy_low++;
      in_run = (k >= rl + 1) && (k <= rl + n);
      check_eq("bit_valid", 64'(gv), 64'(in_run));
      check_eq("done", 64'(gd), 64'(k == rl + n));
      if (in_run) begin
        exp_bits = '0;
        for (int i = 0; i < lanes; i++)
          exp_bits[i] = (ops[i] > rng_word(i, c0 + int'(k - rl - 1)));
        check_eq("bits", 64'(got_bits), 64'(exp_bits));
        for (int i = 0; i < lanes; i++) begin
          ones[i] += int'(got_bits[i]);
          exp_ones[i] += int'(exp_bits[i]);
        end
      end
      if (k == rl + abort_at) begin
        if (use_b) b_abort = 1'b1; else a_abort = 1'b1;
        @(posedge clk); #1;
        sample(use_b, gv, gd, gr, ge, got_bits);
        check_eq("abort_valid", 64'(gv), 64'(0));
        check_eq("abort_done", 64'(gd), 64'(0));
        check_eq("abort_ready", 64'(gr), 64'(1));
        check_eq("abort_rng_en", 64'(ge), 64'(0));
        check_eq("abort_bits", 64'(got_bits), 64'(0));
        if (use_b) b_abort = 1'b0; else a_abort = 1'b0;
        $display("stream %s op0=%02h aborted at run cycle %0d", use_b ? "B" : "A", ops[0], abort_at);
        return;
      end
      if (k == rl + reset_at) begin
        #3 rst_n = 1'b0;
        #1;
        sample(use_b, gv, gd, gr, ge, got_bits);
        check_eq("rst_valid", 64'(gv), 64'(0));
        check_eq("rst_done", 64'(gd), 64'(0));
        check_eq("rst_rng_en", 64'(ge), 64'(0));
        check_eq("rst_bits", 64'(got_bits), 64'(0));
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("stream %s op0=%02h reset at run cycle %0d", use_b ? "B" : "A", ops[0], reset_at);
        return;
      end
    end
    check_eq("rng_en_cycles", 64'(en_cyc), 64'(rl + n));
    check_eq("ready_low_cycles", 64'(rdy_low), 64'(rl + n + 1));
    for (int i = 0; i < lanes; i++)
      check_eq($sformatf("ones_lane%0d", i), 64'(ones[i]), 64'(use_b ? exp_ones[i] : int'(ops[i])));
    $display("stream %s op0=%02h op1=%02h c0=%0d ones0=%0d ones1=%0d", use_b ? "B" : "A",
             ops[0], ops[1], c0, ones[0], ones[1]);
  endtask

  task automatic fill_ops(input bit rnd, input logic [7:0] val);
    for (int i = 0; i < LA; i++) cur_ops[i] = rnd ? 8'($urandom_range(0, 255)) : val;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_abort = 1'b0;
    b_abort = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_valid", 64'(a_bit_valid), 64'(0));
    check_eq("rst_a_done", 64'(a_done), 64'(0));
    check_eq("rst_a_rng_en", 64'(a_rng_enable), 64'(0));
    check_eq("rst_a_bits", 64'(a_bit_out), 64'(0));
    check_eq("rst_b_valid", 64'(b_bit_valid), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_a_ready", 64'(a_in_ready), 64'(1));
    check_eq("rel_b_ready", 64'(b_in_ready), 64'(1));

    fill_ops(1'b0, 8'h50);
    run_stream(1'b0, -1000, -1000, 1'b0, 8'h00);

    for (int i = 0; i < LA; i++) cur_ops[i] = (i % 2 == 0) ? 8'h00 : 8'hFF;
    cur_ops[5] = 8'h01;
    run_stream(1'b0, -1000, -1000, 1'b0, 8'h00);

    fill_ops(1'b0, 8'h20);
    run_stream(1'b0, -1000, -1000, 1'b1, 8'hC0);
    fill_ops(1'b0, 8'hC0);
    run_stream(1'b0, -1000, -1000, 1'b0, 8'h00);

    // abort while idle must block the handshake
    fill_ops(1'b1, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h00);
    a_abort = 1'b1;
    @(posedge clk); #1;
    check_eq("idle_abort_rng_en", 64'(a_rng_enable), 64'(0));
    check_eq("idle_abort_ready", 64'(a_in_ready), 64'(1));
    a_abort = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    fill_ops(1'b1, 8'h00);
    run_stream(1'b0, 100, -1000, 1'b0, 8'h00);
    fill_ops(1'b1, 8'h00);
    run_stream(1'b0, -1000, -1000, 1'b0, 8'h00);

    fill_ops(1'b1, 8'h00);
    run_stream(1'b0, -1000, 50, 1'b0, 8'h00);
    fill_ops(1'b0, 8'h80);
    run_stream(1'b0, -1000, -1000, 1'b0, 8'h00);

    fill_ops(1'b0, 8'h80);
    run_stream(1'b1, -1000, -1000, 1'b0, 8'h00);
    for (int t = 0; t < 3; t++) begin
      fill_ops(1'b1, 8'h00);
      run_stream(1'b1, -1000, -1000, 1'b0, 8'h00);
    end
    fill_ops(1'b1, 8'h00);
    run_stream(1'b1, 7, -1000, 1'b0, 8'h00);

    fill_ops(1'b1, 8'h00);
    run_stream(1'b0, -1000, -1000, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
